// File: rtl/auto_ta_sc_loader.sv
`default_nettype none
// ============================================================================
// Module   : auto_ta_sc_loader
// Brief    : Latches a DAC code and channel mask, shifts the frame into the
//            SKIROC slow-control register, optionally reads it back, then
//            strobes the load and signals completion.
// Revision : 1.0 - initial release
// ============================================================================
module auto_ta_sc_loader #(
    parameter int DAC_W    = 12,
    parameter int MASK_W   = 64,
    parameter int SR_HALF  = 5,
    parameter int RSTB_LEN = 4,
    parameter int LOAD_LEN = 4,
    parameter int VERIFY   = 1
) (
    input  logic              Clk_10MHz,
    input  logic              Rst,
    input  logic              In_Set_SC,
    input  logic [DAC_W-1:0]  In_DAC_Code,
    input  logic [MASK_W-1:0] In_Mask_Code,
    input  logic              In_SR_Out,
    output logic              Out_SR_Clk,
    output logic              Out_SR_In,
    output logic              Out_SR_Rstb,
    output logic              Out_Load_SC,
    output logic              Out_Finish_Sc,
    output logic              Out_Busy,
    output logic              Out_Verify_Err,
    output logic [7:0]        Out_Err_Cnt
);

    localparam int c_FRAME_LEN = DAC_W + MASK_W;
    localparam int c_BIT_W     = $clog2(c_FRAME_LEN + 1);

    localparam logic [15:0] c_SLOT_LAST = 16'(2 * SR_HALF - 1);
    localparam logic [15:0] c_SAMPLE    = 16'(SR_HALF - 1);
    localparam logic [15:0] c_HALF      = 16'(SR_HALF);
    localparam logic [15:0] c_RSTB_LAST = 16'(RSTB_LEN - 1);
    localparam logic [15:0] c_LOAD_LAST = 16'(LOAD_LEN - 1);
    localparam logic [15:0] c_DONE_LAST = 16'd1;

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME_LEN - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_RSTB   = 3'd1;
    localparam logic [2:0] c_SHIFT  = 3'd2;
    localparam logic [2:0] c_VERIFY = 3'd3;
    localparam logic [2:0] c_LOAD   = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [15:0]            r_cnt;
    logic [c_BIT_W-1:0]     r_bit;
    logic [c_FRAME_LEN-1:0] r_frame;
    logic [c_FRAME_LEN-1:0] r_shift;
    logic                   r_set_d;
    logic                   r_err;
    logic                   r_verify_err;
    logic [7:0]             r_err_cnt;

    logic w_trigger;
    logic w_serial;
    logic w_slot_end;
    logic w_last_bit;

    assign w_trigger  = In_Set_SC && !r_set_d && (r_state == c_IDLE);
    assign w_serial   = (r_state == c_SHIFT) || (r_state == c_VERIFY);
    assign w_slot_end = w_serial && (r_cnt == c_SLOT_LAST);
    assign w_last_bit = (r_bit == c_BIT_LAST);

    always_ff @(posedge Clk_10MHz) begin
        if (Rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_trigger) w_state_nxt = c_RSTB;
            c_RSTB:   if (r_cnt == c_RSTB_LAST) w_state_nxt = c_SHIFT;
            c_SHIFT:  if (w_slot_end && w_last_bit)
                          w_state_nxt = (VERIFY != 0) ? c_VERIFY : c_LOAD;
            c_VERIFY: if (w_slot_end && w_last_bit) w_state_nxt = c_LOAD;
            c_LOAD:   if (r_cnt == c_LOAD_LAST) w_state_nxt = c_DONE;
            c_DONE:   if (r_cnt == c_DONE_LAST) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge Clk_10MHz) begin
        if (Rst) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_frame      <= '0;
            r_shift      <= '0;
            r_set_d      <= 1'b0;
            r_err        <= 1'b0;
            r_verify_err <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_set_d <= In_Set_SC;

            if ((r_state == c_IDLE) || (w_state_nxt != r_state) || w_slot_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_trigger) begin
                        r_frame <= {In_DAC_Code, In_Mask_Code};
                        r_shift <= {In_DAC_Code, In_Mask_Code};
                        r_bit   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                c_SHIFT, c_VERIFY: begin
                    // readback is compared just before the ASIC clocks the next bit
                    if ((r_state == c_VERIFY) && (r_cnt == c_SAMPLE)
                        && (In_SR_Out != r_shift[c_FRAME_LEN-1])) begin
                        r_err <= 1'b1;
                    end
                    if (w_slot_end) begin
                        if (w_last_bit) begin
                            r_bit   <= '0;
                            r_shift <= r_frame;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {r_shift[c_FRAME_LEN-2:0], 1'b0};
                        end
                    end
                end
                c_DONE: begin
                    if (r_cnt == 16'd0) begin
                        r_verify_err <= r_err;
                        if (r_err && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Out_SR_Clk     = w_serial && (r_cnt >= c_HALF);
    assign Out_SR_In      = w_serial && r_shift[c_FRAME_LEN-1];
    assign Out_SR_Rstb    = (r_state != c_RSTB);
    assign Out_Load_SC    = (r_state == c_LOAD);
    assign Out_Finish_Sc  = (r_state == c_DONE);
    assign Out_Busy       = (r_state != c_IDLE);
    assign Out_Verify_Err = r_verify_err;
    assign Out_Err_Cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_auto_ta_sc_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_auto_ta_sc_loader
// Brief    : Self-checking bench with an ASIC shift-register loopback model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_auto_ta_sc_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        set_a = 1'b0, set_b = 1'b0, set_c = 1'b0;
    logic [11:0] dac_in = '0;
    logic [63:0] mask_in = '0;
    logic [1:0]  c_dac = '0, c_mask = '0;

    logic       a_sr_clk, a_sr_in, a_rstb, a_load, a_fin, a_busy, a_verr;
    logic [7:0] a_ecnt;
    logic       b_sr_clk, b_sr_in, b_rstb, b_load, b_fin, b_busy, b_verr;
    logic [7:0] b_ecnt;
    logic       c_sr_clk, c_sr_in, c_rstb, c_load, c_fin, c_busy, c_verr;
    logic [7:0] c_ecnt;
    logic       c_sr_out;

    logic        a_sr_out = 1'b0;
    logic [75:0] a_asic = '0;
    logic        a_bits[$];
    logic        b_bits[$];
    int          a_base = 0;
    bit          flip_en = 1'b0;
    int          flip_idx = 0;

    int total = 0;
    int bad   = 0;
    int ref_cnt = 0;

    assign c_sr_out = ~c_sr_in;

    auto_ta_sc_loader u_dut_a (
        .Clk_10MHz(clk), .Rst(rst), .In_Set_SC(set_a), .In_DAC_Code(dac_in),
        .In_Mask_Code(mask_in), .In_SR_Out(a_sr_out), .Out_SR_Clk(a_sr_clk),
        .Out_SR_In(a_sr_in), .Out_SR_Rstb(a_rstb), .Out_Load_SC(a_load),
        .Out_Finish_Sc(a_fin), .Out_Busy(a_busy), .Out_Verify_Err(a_verr),
        .Out_Err_Cnt(a_ecnt)
    );

    auto_ta_sc_loader #(.VERIFY(0)) u_dut_b (
        .Clk_10MHz(clk), .Rst(rst), .In_Set_SC(set_b), .In_DAC_Code(dac_in),
        .In_Mask_Code(mask_in), .In_SR_Out(1'b0), .Out_SR_Clk(b_sr_clk),
        .Out_SR_In(b_sr_in), .Out_SR_Rstb(b_rstb), .Out_Load_SC(b_load),
        .Out_Finish_Sc(b_fin), .Out_Busy(b_busy), .Out_Verify_Err(b_verr),
        .Out_Err_Cnt(b_ecnt)
    );

    auto_ta_sc_loader #(.DAC_W(2), .MASK_W(2), .SR_HALF(1), .RSTB_LEN(1),
                        .LOAD_LEN(1), .VERIFY(1)) u_dut_c (
        .Clk_10MHz(clk), .Rst(rst), .In_Set_SC(set_c), .In_DAC_Code(c_dac),
        .In_Mask_Code(c_mask), .In_SR_Out(c_sr_out), .Out_SR_Clk(c_sr_clk),
        .Out_SR_In(c_sr_in), .Out_SR_Rstb(c_rstb), .Out_Load_SC(c_load),
        .Out_Finish_Sc(c_fin), .Out_Busy(c_busy), .Out_Verify_Err(c_verr),
        .Out_Err_Cnt(c_ecnt)
    );

    // 76-stage ASIC register; optionally corrupts one readback bit
    always @(posedge a_sr_clk) begin
        a_bits.push_back(a_sr_in);
        a_asic   = {a_asic[74:0], a_sr_in};
        a_sr_out = a_asic[75] ^ (flip_en && ((a_bits.size() - a_base) == 76 + flip_idx));
    end

    always @(posedge b_sr_clk) b_bits.push_back(b_sr_in);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_a(input logic [11:0] dac, input logic [63:0] mask, input bit fen,
                         input int fidx, output logic verr, output logic [7:0] ecnt);
        int n;
        logic [75:0] fr, p0, p1;
        fr = {dac, mask};
        p0 = '0;
        p1 = '0;
        flip_en  = fen;
        flip_idx = fidx;
        a_base   = a_bits.size();
        @(negedge clk);
        set_a = 1'b1; dac_in = dac; mask_in = mask;
        @(negedge clk);
        set_a = 1'b0; dac_in = 12'($urandom); mask_in = {$urandom, $urandom};
        n = 1;
        check("busy_rise", a_busy, 1'b1);
        while (!a_fin && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("finish_latency", n, 1529);
        @(negedge clk);
        check("finish_width", {a_fin, a_busy}, 2'b11);
        @(negedge clk);
        check("finish_end", {a_fin, a_busy}, 2'b00);
        check("rise_count", a_bits.size() - a_base, 152);
        for (int i = 0; i < 76; i++) begin
            if (a_base + i < a_bits.size())      p0[75-i] = a_bits[a_base + i];
            if (a_base + 76 + i < a_bits.size()) p1[75-i] = a_bits[a_base + 76 + i];
        end
        check("frame_pass1", p0, fr);
        check("frame_pass2", p1, fr);
        verr = a_verr;
        ecnt = a_ecnt;
    endtask

    task automatic count_fin(input int cyc, output int nr);
        logic prev;
        prev = a_fin;
        nr = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (a_fin && !prev) nr++;
            prev = a_fin;
        end
    endtask

    typedef struct {
        logic [11:0] dac;
        logic [63:0] mask;
        bit          fen;
        int          fidx;
        bit          exp_err;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       verr;
        logic [7:0] ecnt;
        int         n, nr, loads;
        logic       load_prev;
        logic [75:0] bf;
        bit         fen;

        vecs[0] = '{12'hA00, 64'h0,                     1'b0, 0,  1'b0, 0};
        vecs[1] = '{12'h001, 64'h8000_0000_0000_0001,   1'b1, 40, 1'b1, 1};
        vecs[2] = '{12'h001, 64'h8000_0000_0000_0001,   1'b0, 0,  1'b0, 1};
        vecs[3] = '{12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF,   1'b1, 0,  1'b1, 2};
        vecs[4] = '{12'h555, 64'hAAAA_5555_F0F0_0F0F,   1'b1, 75, 1'b1, 3};
        vecs[5] = '{12'h000, 64'h0,                     1'b0, 0,  1'b0, 3};

        repeat (3) @(negedge clk);
        check("rst_outputs", {a_sr_clk, a_sr_in, a_rstb, a_load, a_fin, a_busy, a_verr}, 7'b0010000);
        check("rst_err_cnt", a_ecnt, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_a(vecs[v].dac, vecs[v].mask, vecs[v].fen, vecs[v].fidx, verr, ecnt);
            check("tbl_verify_err", verr, vecs[v].exp_err);
            check("tbl_err_cnt", ecnt, vecs[v].exp_cnt);
        end
        ref_cnt = 3;

        for (int r = 0; r < 6; r++) begin
            fen = 1'($urandom);
            run_a(12'($urandom), {$urandom, $urandom}, fen, int'($urandom_range(0, 75)), verr, ecnt);
            if (fen && ref_cnt < 255) ref_cnt++;
            check("rnd_verify_err", verr, fen);
            check("rnd_err_cnt", ecnt, ref_cnt);
        end

        // level held high triggers once
        flip_en = 1'b0;
        @(negedge clk); set_a = 1'b1;
        count_fin(3000, nr);
        set_a = 1'b0;
        check("hold_one_txn", nr, 1);
        @(negedge clk); set_a = 1'b1;
        @(negedge clk); set_a = 1'b0;
        count_fin(100, nr);
        check("busy_no_finish_yet", nr, 0);
        @(negedge clk); set_a = 1'b1;
        @(negedge clk); set_a = 1'b0;
        count_fin(3000, nr);
        check("pulse_in_busy_ignored", nr, 1);
        check("hold_err_cnt", a_ecnt, ref_cnt);
        run_a(12'h3C5, 64'hDEAD_BEEF_0000_1234, 1'b0, 0, verr, ecnt);
        check("after_busy_verify_err", verr, 1'b0);

        // reset in the middle of SHIFT
        @(negedge clk); set_a = 1'b1;
        @(negedge clk); set_a = 1'b0;
        repeat (404) @(negedge clk);
        check("pre_rst_shifting", a_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {a_sr_clk, a_rstb, a_load, a_fin, a_busy}, 5'b01000);
        check("midrst_err_cnt", a_ecnt, 8'd0);
        rst = 1'b0;
        ref_cnt = 0;
        count_fin(2000, nr);
        check("midrst_no_finish", nr, 0);
        run_a(12'h0F0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, verr, ecnt);
        check("post_rst_verify_err", verr, 1'b0);
        check("post_rst_err_cnt", ecnt, 8'd0);

        // verify-less build
        n = b_bits.size();
        @(negedge clk); set_b = 1'b1; dac_in = 12'h5A3; mask_in = 64'h0123_4567_89AB_CDEF;
        @(negedge clk); set_b = 1'b0; dac_in = 12'h000; mask_in = 64'h0;
        nr = 1; loads = 0; load_prev = 1'b0;
        while (!b_fin && nr < 4000) begin
            load_prev = b_load;
            if (b_load) loads++;
            @(negedge clk);
            nr++;
        end
        check("nv_latency", nr, 769);
        check("nv_load_cycles", loads, 4);
        check("nv_load_before_finish", {load_prev, b_load}, 2'b10);
        check("nv_rise_count", b_bits.size() - n, 76);
        bf = '0;
        for (int i = 0; i < 76; i++)
            if (n + i < b_bits.size()) bf[75-i] = b_bits[n + i];
        check("nv_frame", bf, {12'h5A3, 64'h0123_4567_89AB_CDEF});
        repeat (3) @(negedge clk);
        check("nv_verify_err", {b_verr, b_ecnt}, 9'd0);

        // saturation on a small always-failing build
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk); set_c = 1'b1; c_dac = 2'($urandom); c_mask = 2'($urandom);
            @(negedge clk); set_c = 1'b0;
            n = 1;
            while (!c_fin && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (k == 1) check("small_latency", n, 19);
            repeat (2) @(negedge clk);
            if (k == 1 || k == 255 || k == 260)
                check("err_cnt_sat", {c_verr, c_ecnt}, {1'b1, 8'((k > 255) ? 255 : k)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
